// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain
//   Elastic pipeline of DEPTH registered stages, each WIDTH bits wide with
//   its own valid bit. Valid/ready handshake on both ends. A stage moves
//   forward whenever the stage after it is empty or is itself moving, so
//   bubbles collapse under backpressure. Also provides a global freeze
//   (en), a synchronous flush and a registered occupancy count.
//
// Ports
//   clk        in   rising-edge clock
//   clr        in   asynchronous active-high reset
//   en         in   global enable; low freezes every register and transfer
//   flush      in   synchronous flush of all stages (ignored while en=0)
//   in_data    in   upstream data
//   in_valid   in   upstream data valid
//   in_ready   out  stage 0 can take a word this cycle
//   out_data   out  data register of the last stage
//   out_valid  out  last stage holds valid data, masked by en
//   out_ready  in   downstream accepts this cycle
//   count      out  number of valid stages, 0..DEPTH
module pipe_reg_chain #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       en,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic             go;
  logic             accept;
  logic             flush_now;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] v_reg;
  logic [DEPTH-1:0] v_next;
  logic [WIDTH-1:0] d_reg  [DEPTH];
  logic [WIDTH-1:0] d_next [DEPTH];
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;

  assign go        = en & ~flush;
  assign flush_now = en & flush;

  // The recursive advance rule unrolls to: a valid stage advances when
  // out_ready is high or any stage downstream of it is empty. Walking from
  // the output end with a running "room" flag gives the same result without
  // a combinational chain between vector bits.
  always_comb begin : adv_calc
    logic room;
    room = out_ready;
    adv  = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      adv[i] = go & v_reg[i] & room;
      room   = room | ~v_reg[i];
    end
  end

  // in_ready never looks at in_valid; out_ready reaches it only via adv[0].
  assign in_ready = go & (~v_reg[0] | adv[0]);
  assign accept   = in_valid & in_ready;

  // Per-stage next state: a stage is refilled from upstream (or from the
  // input port for stage 0); if it advances without a refill it empties
  // but keeps its data register unchanged.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             fill;
      logic [WIDTH-1:0] src;

      if (gi == 0) begin : g_head
        assign fill = accept;
        assign src  = in_data;
      end else begin : g_body
        assign fill = adv[gi-1];
        assign src  = d_reg[gi-1];
      end

      assign v_next[gi] = flush_now ? 1'b0 :
                          fill      ? 1'b1 :
                          adv[gi]   ? 1'b0 : v_reg[gi];
      assign d_next[gi] = flush_now ? RESET_VAL :
                          fill      ? src       : d_reg[gi];
    end
  endgenerate

  always_comb begin
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + CW'(v_next[i]);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      v_reg     <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_reg[i] <= RESET_VAL;
      end
    end else begin
      v_reg     <= v_next;
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) begin
        d_reg[i] <= d_next[i];
      end
    end
  end

  assign out_data  = d_reg[DEPTH-1];
  assign out_valid = en & v_reg[DEPTH-1];
  assign count     = count_reg;

endmodule
